// File: rtl/image_frame_packetizer_if.sv
// rtl/image_frame_packetizer_if.sv - pixel input and packet output streams of the frame packetizer
interface image_frame_packetizer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;
    logic [1:0]        out_kind;
    logic              line_end;

    modport master (
        output pix_data, pix_valid, out_ready,
        input  pix_ready, out_data, out_valid, out_sop, out_eop, out_kind, line_end
    );

    modport slave (
        input  pix_data, pix_valid, out_ready,
        output pix_ready, out_data, out_valid, out_sop, out_eop, out_kind, line_end
    );
endinterface

// File: rtl/image_frame_packetizer.sv
// rtl/image_frame_packetizer.sv - frames a pixel stream into header/pixels/checksum packets
// Optional FRAME_CNT_EN: appends a wrapping frame counter as a fourth header word.
module image_frame_packetizer #(
    parameter int         DATA_W     = 8,
    parameter int         IMG_WIDTH  = 346,
    parameter int         IMG_HEIGHT = 371,
    parameter logic [7:0] SYNC_WORD  = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     frame_done,
    image_frame_packetizer_if.slave  bus
);
`ifdef FRAME_CNT_EN
    localparam int HDR_N = 4;
`else
    localparam int HDR_N = 3;
`endif
    localparam logic [1:0] HDR_LAST = 2'(HDR_N - 1);
    localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int LINE_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PIX, CSUM} state_t;
    state_t state, state_next;

    logic [1:0]        hdr_idx;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] hdr_word;

    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic [1:0]        kind_r;
    logic              sop_r;
    logic              eop_r;
    logic              le_r;

    logic              can_load;
    logic              load;
    logic [DATA_W-1:0] ld_data;
    logic [1:0]        ld_kind;
    logic              ld_sop;
    logic              ld_eop;
    logic              ld_le;
    logic              pix_ready;
    logic              pix_take;
    logic              hdr_enter;
    logic              col_last;
    logic              line_last;

`ifdef FRAME_CNT_EN
    logic [DATA_W-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + DATA_W'(1);
        end
    end
`endif

    always_comb begin
        hdr_word = '0;
        case (hdr_idx)
            2'd0:    hdr_word = DATA_W'(SYNC_WORD);
            2'd1:    hdr_word = DATA_W'(IMG_WIDTH);
            2'd2:    hdr_word = DATA_W'(IMG_HEIGHT);
`ifdef FRAME_CNT_EN
            default: hdr_word = frame_cnt;
`else
            default: hdr_word = '0;
`endif
        endcase
    end

    // The output register accepts a new word when empty or draining this cycle.
    assign can_load  = !valid_r || bus.out_ready;
    assign col_last  = (col == COL_W'(IMG_WIDTH - 1));
    assign line_last = (line == LINE_W'(IMG_HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        ld_data    = '0;
        ld_kind    = 2'd0;
        ld_sop     = 1'b0;
        ld_eop     = 1'b0;
        ld_le      = 1'b0;
        pix_ready  = 1'b0;
        pix_take   = 1'b0;
        hdr_enter  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HDR;
                    hdr_enter  = 1'b1;
                end
            end
            HDR: begin
                if (can_load) begin
                    load    = 1'b1;
                    ld_data = hdr_word;
                    ld_sop  = (hdr_idx == 2'd0);
                    if (hdr_idx == HDR_LAST) begin
                        state_next = PIX;
                    end
                end
            end
            PIX: begin
                pix_ready = can_load;
                if (can_load && bus.pix_valid) begin
                    pix_take = 1'b1;
                    load     = 1'b1;
                    ld_data  = bus.pix_data;
                    ld_kind  = 2'd1;
                    ld_le    = col_last;
                    if (col_last && line_last) begin
                        state_next = CSUM;
                    end
                end
            end
            CSUM: begin
                // Once the checksum sits in the register, only wait for its acceptance.
                if (valid_r && eop_r) begin
                    if (bus.out_ready) begin
                        state_next = IDLE;
                    end
                end else if (can_load) begin
                    load    = 1'b1;
                    ld_data = acc;
                    ld_kind = 2'd2;
                    ld_eop  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_idx <= 2'd0;
            col     <= '0;
            line    <= '0;
            acc     <= '0;
        end else begin
            if (hdr_enter) begin
                hdr_idx <= 2'd0;
                col     <= '0;
                line    <= '0;
                acc     <= '0;
            end else if (state == HDR && load) begin
                hdr_idx <= hdr_idx + 2'd1;
            end
            if (pix_take) begin
                acc <= acc + bus.pix_data;
                if (col_last) begin
                    col  <= '0;
                    line <= line_last ? '0 : line + LINE_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            kind_r  <= 2'd0;
            sop_r   <= 1'b0;
            eop_r   <= 1'b0;
            le_r    <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= ld_data;
            kind_r  <= ld_kind;
            sop_r   <= ld_sop;
            eop_r   <= ld_eop;
            le_r    <= ld_le;
        end else if (bus.out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign busy          = (state != IDLE);
    assign frame_done    = (state == CSUM) && valid_r && eop_r && bus.out_ready;
    assign bus.pix_ready = pix_ready;
    assign bus.out_data  = data_r;
    assign bus.out_valid = valid_r;
    assign bus.out_kind  = kind_r;
    assign bus.out_sop   = sop_r;
    assign bus.out_eop   = eop_r;
    assign bus.line_end  = le_r;
endmodule

// File: tb/tb_image_frame_packetizer.sv
// tb/tb_image_frame_packetizer.sv - directed self-checking bench for image_frame_packetizer
module tb_image_frame_packetizer;
`ifdef FRAME_CNT_EN
    localparam int HDR_N = 4;
`else
    localparam int HDR_N = 3;
`endif
    localparam int NWORDS = HDR_N + 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, busy_a, done_a;
    logic start_b, busy_b, done_b;
    int   checks   = 0;
    int   failures = 0;

    image_frame_packetizer_if #(.DATA_W(8))  a_if ();
    image_frame_packetizer_if #(.DATA_W(12)) b_if ();

    image_frame_packetizer #(.DATA_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(2), .SYNC_WORD(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .frame_done(done_a), .bus(a_if)
    );

    image_frame_packetizer #(.DATA_W(12), .IMG_WIDTH(4), .IMG_HEIGHT(2), .SYNC_WORD(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .frame_done(done_b), .bus(b_if)
    );

    logic [7:0]  pix_src [8];
    logic [12:0] wq [$];
    int          fc_model;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input bit toggle, input bit poke_start, input int rst_at,
                             input logic [7:0] exp_csum, input string name);
        int pi, first_valid, first_acc, last_acc;
        bit prev_stall, fin;
        logic [7:0] prev_data, exp_d;
        logic [1:0] exp_k;
        logic [12:0] exp_w;
        pi = 0; first_valid = -1; first_acc = -1; last_acc = -1;
        prev_stall = 0; fin = 0; prev_data = '0;
        wq.delete();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int it = 0; it < 200 && !fin; it++) begin
            if (pi == rst_at) begin
                rst = 1'b1;
                step();
                #1;
                checks++;
                if ({a_if.out_valid, a_if.out_sop, a_if.out_eop, a_if.out_kind, a_if.line_end,
                     a_if.pix_ready, busy_a, done_a, a_if.out_data} !== 17'h0) begin
                    failures++;
                    $display("FAIL %s reset_outputs: valid=%b sop=%b eop=%b kind=%0d le=%b prdy=%b busy=%b done=%b data=%h, all required 0",
                             name, a_if.out_valid, a_if.out_sop, a_if.out_eop, a_if.out_kind, a_if.line_end,
                             a_if.pix_ready, busy_a, done_a, a_if.out_data);
                end
                rst = 1'b0;
                fc_model = 0;
                return;
            end
            a_if.out_ready = toggle ? (it % 3 == 0) : 1'b1;
            a_if.pix_valid = (pi < 8);
            a_if.pix_data  = pix_src[(pi < 8) ? pi : 0];
            start_a        = poke_start && (pi == 4);
            #1;
            if (it == 0) begin
                checks++;
                if (busy_a !== 1'b1 || a_if.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_after_start: busy=%b valid=%b, required busy=1 valid=0", name, busy_a, a_if.out_valid);
                end
            end
            if (a_if.out_valid && first_valid < 0) first_valid = it;
            if (prev_stall) begin
                checks++;
                if (a_if.out_valid !== 1'b1 || a_if.out_data !== prev_data) begin
                    failures++;
                    $display("FAIL %s stall_hold: valid=%b data=%h, required valid=1 data=%h", name, a_if.out_valid, a_if.out_data, prev_data);
                end
            end
            if (a_if.out_valid && !a_if.out_ready) begin
                checks++;
                if (a_if.pix_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s stall_pix_ready: pix_ready=%b, required 0", name, a_if.pix_ready);
                end
            end
            prev_stall = a_if.out_valid && !a_if.out_ready;
            prev_data  = a_if.out_data;
            if (a_if.out_valid && a_if.out_ready) begin
                wq.push_back({a_if.out_data, a_if.out_kind, a_if.out_sop, a_if.out_eop, a_if.line_end});
                if (first_acc < 0) first_acc = it;
                last_acc = it;
            end
            if (a_if.pix_valid && a_if.pix_ready) pi++;
            if (done_a) begin
                fin = 1;
                if (poke_start) start_a = 1'b1;
            end
            step();
        end
        start_a = 1'b0;
        a_if.pix_valid = 1'b0;
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL %s frame_done_timeout: no frame_done within 200 cycles, required one", name);
            return;
        end
        checks++;
        if (wq.size() != NWORDS) begin
            failures++;
            $display("FAIL %s word_count: got %0d words, required %0d", name, wq.size(), NWORDS);
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                exp_k = 2'd0;
                if (i == 0)                 exp_d = 8'hA5;
                else if (i == 1)            exp_d = 8'h04;
                else if (i == 2)            exp_d = 8'h02;
                else if (i < HDR_N)         exp_d = fc_model[7:0];
                else if (i < HDR_N + 8) begin
                    exp_d = pix_src[i - HDR_N];
                    exp_k = 2'd1;
                end else begin
                    exp_d = exp_csum;
                    exp_k = 2'd2;
                end
                exp_w = {exp_d, exp_k, (i == 0), (i == NWORDS - 1),
                         (i == HDR_N + 3) || (i == HDR_N + 7)};
                checks++;
                if (wq[i] !== exp_w) begin
                    failures++;
                    $display("FAIL %s word%0d {data,kind,sop,eop,line_end}: got %h/%0d/%b/%b/%b, required %h/%0d/%b/%b/%b",
                             name, i, wq[i][12:5], wq[i][4:3], wq[i][2], wq[i][1], wq[i][0],
                             exp_w[12:5], exp_w[4:3], exp_w[2], exp_w[1], exp_w[0]);
                end
            end
        end
        fc_model = (fc_model + 1) % 256;
        if (!toggle) begin
            checks++;
            if (first_valid != 1 || last_acc - first_acc != NWORDS - 1) begin
                failures++;
                $display("FAIL %s latency_back_to_back: first_valid=%0d span=%0d, required 1 and %0d",
                         name, first_valid, last_acc - first_acc, NWORDS - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        checks++;
        if ({a_if.out_valid, a_if.out_sop, a_if.out_eop, a_if.out_kind, a_if.line_end, a_if.pix_ready,
             busy_a, done_a, busy_b, done_b, b_if.out_valid} !== 12'h0 || a_if.out_data !== 8'h0) begin
            failures++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b data=%h busy_b=%b, all required 0",
                     a_if.out_valid, busy_a, done_a, a_if.out_data, busy_b);
        end
        rst = 1'b0;
        fc_model = 0;
        step();
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) pix_src[i] = 8'(i + 1);
    endtask

    task automatic test_basic();
        load_ramp();
        run_frame(1'b0, 1'b0, -1, 8'h24, "basic");
    endtask

    task automatic test_stall();
        load_ramp();
        run_frame(1'b1, 1'b0, -1, 8'h24, "stall");
    endtask

    task automatic test_checksum_wrap();
        for (int i = 0; i < 8; i++) pix_src[i] = 8'hFF;
        run_frame(1'b0, 1'b0, -1, 8'hF8, "csum_wrap");
    endtask

    task automatic test_start_ignored();
        load_ramp();
        run_frame(1'b0, 1'b1, -1, 8'h24, "start_ignored");
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (busy_a !== 1'b0 || a_if.out_valid !== 1'b0 || done_a !== 1'b0) begin
                failures++;
                $display("FAIL start_ignored idle%0d: busy=%b valid=%b done=%b, all required 0", k, busy_a, a_if.out_valid, done_a);
            end
            step();
        end
        run_frame(1'b0, 1'b0, -1, 8'h24, "after_ignored");
    endtask

    task automatic test_reset_mid_frame();
        load_ramp();
        run_frame(1'b0, 1'b0, 3, 8'h00, "reset_mid");
        step();
        run_frame(1'b0, 1'b0, -1, 8'h24, "after_reset");
    endtask

    task automatic test_wide();
        int n;
        bit fin;
        logic [11:0] first_w, last_w;
        logic [1:0]  last_k;
        n = 0; fin = 0; first_w = '0; last_w = '0; last_k = '0;
        b_if.out_ready = 1'b1;
        b_if.pix_valid = 1'b1;
        b_if.pix_data  = 12'hFFF;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int it = 0; it < 100 && !fin; it++) begin
            #1;
            if (b_if.out_valid && b_if.out_ready) begin
                if (n == 0) first_w = b_if.out_data;
                last_w = b_if.out_data;
                last_k = b_if.out_kind;
                n++;
            end
            if (done_b) fin = 1;
            step();
        end
        b_if.pix_valid = 1'b0;
        checks++;
        if (!fin || n != NWORDS) begin
            failures++;
            $display("FAIL wide_frame: done=%b words=%0d, required done=1 words=%0d", fin, n, NWORDS);
        end
        checks++;
        if (first_w !== 12'h0A5) begin
            failures++;
            $display("FAIL wide_sync: got %h, required 0a5", first_w);
        end
        checks++;
        if (last_w !== 12'hFF8 || last_k !== 2'd2) begin
            failures++;
            $display("FAIL wide_checksum: got %h kind %0d, required ff8 kind 2", last_w, last_k);
        end
    endtask

    task automatic test_frame_cnt();
`ifdef FRAME_CNT_EN
        load_ramp();
        for (int f = 0; f < 257; f++) run_frame(1'b0, 1'b0, -1, 8'h24, "frame_cnt");
`endif
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        a_if.pix_data = '0; a_if.pix_valid = 1'b0; a_if.out_ready = 1'b0;
        b_if.pix_data = '0; b_if.pix_valid = 1'b0; b_if.out_ready = 1'b0;
        fc_model = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_checksum_wrap();
        test_start_ignored();
        test_reset_mid_frame();
        test_wide();
        test_frame_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
